// File: rtl/fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory request/grant and decode valid/ready.
// master is the fetch queue; slave is the memory/decode environment.
interface fetch_queue_if #(
    parameter int IW = 16,
    parameter int AW = 16
);
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_gnt;
    logic [IW-1:0]     mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [IW/2-1:0]   instr_code_high;
    logic [IW/2-1:0]   instr_code_low;
    logic [AW-1:0]     instr_pc;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr_code_high,
        output instr_code_low,
        output instr_pc
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr_code_high,
        input  instr_code_low,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch FIFO of {instruction, pc}.
// Redirect flushes the FIFO and any in-flight response, then restarts at redirect_pc.
module fetch_queue #(
    parameter int IW     = 16,
    parameter int AW     = 16,
    parameter int DEPTH  = 4,
    parameter int PC_INC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [AW-1:0]            boot_pc,
    input  logic                     redirect,
    input  logic [AW-1:0]            redirect_pc,
    fetch_queue_if.master            bus,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [AW-1:0] pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;

    logic [IW-1:0] instr_mem_q [DEPTH];
    logic [AW-1:0] pc_mem_q    [DEPTH];

    logic [CW:0]   credit_used;
    logic          mem_req_w;
    logic          accept;
    logic          push;
    logic          pop;
    logic          valid_w;
    logic [IW-1:0] head_instr;

    // Credit counts the in-flight response so it always finds a free slot.
    assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign mem_req_w   = enable & ~redirect & ~reset & (credit_used < DEPTH_C);
    assign accept      = mem_req_w & bus.mem_gnt;
    assign valid_w     = (count_q != '0);
    assign push        = inflight_q & ~redirect;
    assign pop         = valid_w & bus.instr_ready & ~redirect;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect) begin
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            inflight_d = accept;
            if (accept) begin
                inflight_pc_d = pc_q;
                pc_d          = pc_q + AW'(PC_INC);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= boot_pc;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            instr_mem_q[wr_ptr_q] <= bus.mem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assign head_instr          = instr_mem_q[rd_ptr_q];
    assign bus.mem_req         = mem_req_w;
    assign bus.mem_addr        = pc_q;
    assign bus.instr_valid     = valid_w;
    assign bus.instr_code_high = head_instr[IW-1:IW/2];
    assign bus.instr_code_low  = head_instr[IW/2-1:0];
    assign bus.instr_pc        = pc_mem_q[rd_ptr_q];
    assign occupancy           = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: boot, throughput, full/backpressure, grant stalls,
// redirect over an in-flight request, PC wrap, enable drop and reset while full.
module tb_fetch_queue;
    localparam int IW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          redirect;
    logic [AW-1:0] boot_pc;
    logic [AW-1:0] redirect_pc;
    logic [2:0]    occupancy;
    logic [IW-1:0] xor_mask;

    int n_vec = 0;
    int n_err = 0;

    logic [AW-1:0] out_pc[$];
    logic [IW-1:0] out_code[$];

    always #5 clk = ~clk;

    fetch_queue_if #(.IW(IW), .AW(AW)) bus ();

    fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .PC_INC(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .boot_pc     (boot_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .occupancy   (occupancy)
    );

    // Memory answers one cycle after the grant; decode side logs every completed pop.
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt) bus.mem_rdata <= bus.mem_addr ^ xor_mask;
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            out_pc.push_back(bus.instr_pc);
            out_code.push_back({bus.instr_code_high, bus.instr_code_low});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        out_pc.delete();
        out_code.delete();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; boot_pc = 16'h000C; enable = 1'b1; redirect = 1'b0;
        redirect_pc = '0; xor_mask = '0; bus.mem_gnt = 1'b1; bus.instr_ready = 1'b1;
        step();
        step();
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_vec++; if (bus.mem_addr !== 16'h000C) begin n_err++; $display("FAIL reset_addr: got %h want 000c", bus.mem_addr); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", bus.mem_req); end
        reset = 1'b0;
        #1;
        n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL boot_req: got %b want 1", bus.mem_req); end
    endtask

    task automatic test_boot();
        step();
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid_early: got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.mem_addr !== 16'h000D) begin n_err++; $display("FAIL boot_addr1: got %h want 000d", bus.mem_addr); end
        step();
        n_vec++; if (bus.instr_valid !== 1'b1) begin n_err++; $display("FAIL boot_valid: got %b want 1", bus.instr_valid); end
        n_vec++; if (bus.instr_pc !== 16'h000C) begin n_err++; $display("FAIL boot_pc: got %h want 000c", bus.instr_pc); end
        n_vec++; if (bus.instr_code_high !== 8'h00) begin n_err++; $display("FAIL boot_code_high: got %h want 00", bus.instr_code_high); end
        n_vec++; if (bus.instr_code_low !== 8'h0C) begin n_err++; $display("FAIL boot_code_low: got %h want 0c", bus.instr_code_low); end
        n_vec++; if (bus.mem_addr !== 16'h000E) begin n_err++; $display("FAIL boot_addr2: got %h want 000e", bus.mem_addr); end
        step();
        n_vec++; if (bus.instr_pc !== 16'h000D) begin n_err++; $display("FAIL boot_pc2: got %h want 000d", bus.instr_pc); end
        n_vec++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL boot_occ: got %0d want 1", occupancy); end
    endtask

    task automatic test_back_to_back();
        out_pc.delete();
        out_code.delete();
        repeat (6) step();
        n_vec++; if (out_pc.size() != 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", out_pc.size()); end
        for (int i = 0; i < 6 && i < out_pc.size(); i++) begin
            n_vec++; if (out_pc[i] !== 16'h000D + 16'(i)) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, out_pc[i], 16'h000D + 16'(i)); end
        end
    endtask

    task automatic test_full();
        int grants;
        grants = 0;
        boot_pc = 16'h0020; bus.instr_ready = 1'b0; bus.mem_gnt = 1'b1; enable = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_req && bus.mem_gnt) grants++;
            step();
        end
        n_vec++; if (grants != 4) begin n_err++; $display("FAIL full_grants: got %0d want 4", grants); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL full_req: got %b want 0", bus.mem_req); end
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL full_occ: got %0d want 4", occupancy); end
        n_vec++; if (bus.instr_pc !== 16'h0020) begin n_err++; $display("FAIL full_head: got %h want 0020", bus.instr_pc); end
        n_vec++; if (bus.mem_addr !== 16'h0024) begin n_err++; $display("FAIL full_addr: got %h want 0024", bus.mem_addr); end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        #1;
        n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL pop_req: got %b want 1", bus.mem_req); end
        n_vec++; if (occupancy !== 3'd3) begin n_err++; $display("FAIL pop_occ: got %0d want 3", occupancy); end
        n_vec++; if (bus.instr_pc !== 16'h0021) begin n_err++; $display("FAIL pop_head: got %h want 0021", bus.instr_pc); end
    endtask

    task automatic test_grant_stall();
        logic          gnt_pat  [8];
        logic [AW-1:0] addr_exp [8];
        gnt_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        addr_exp = '{16'h0040, 16'h0041, 16'h0041, 16'h0041, 16'h0042, 16'h0043, 16'h0043, 16'h0044};
        boot_pc = 16'h0040; bus.instr_ready = 1'b1; enable = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.mem_gnt = gnt_pat[i];
            #1;
            n_vec++; if (bus.mem_addr !== addr_exp[i]) begin n_err++; $display("FAIL stall_addr[%0d]: got %h want %h", i, bus.mem_addr, addr_exp[i]); end
            n_vec++; if (bus.mem_req !== 1'b1) begin n_err++; $display("FAIL stall_req[%0d]: got %b want 1", i, bus.mem_req); end
            step();
        end
        bus.mem_gnt = 1'b0;
        repeat (3) step();
        n_vec++; if (out_pc.size() != 5) begin n_err++; $display("FAIL stall_count: got %0d want 5", out_pc.size()); end
        for (int i = 0; i < 5 && i < out_pc.size(); i++) begin
            n_vec++; if (out_pc[i] !== 16'h0040 + 16'(i)) begin n_err++; $display("FAIL stall_pc[%0d]: got %h want %h", i, out_pc[i], 16'h0040 + 16'(i)); end
            n_vec++; if (out_code[i] !== 16'h0040 + 16'(i)) begin n_err++; $display("FAIL stall_code[%0d]: got %h want %h", i, out_code[i], 16'h0040 + 16'(i)); end
        end
    endtask

    task automatic test_redirect();
        bit seen_10;
        seen_10 = 1'b0;
        boot_pc = 16'h000E; xor_mask = 16'h5A00; bus.instr_ready = 1'b1; bus.mem_gnt = 1'b1; enable = 1'b1;
        do_reset();
        step();
        step();
        step();
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL redir_req: got %b want 0", bus.mem_req); end
        step();
        redirect = 1'b0;
        #1;
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid: got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.mem_addr !== 16'h0100) begin n_err++; $display("FAIL redir_addr: got %h want 0100", bus.mem_addr); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL redir_occ: got %0d want 0", occupancy); end
        step();
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid2: got %b want 0", bus.instr_valid); end
        step();
        n_vec++; if (bus.instr_pc !== 16'h0100) begin n_err++; $display("FAIL redir_pc: got %h want 0100", bus.instr_pc); end
        n_vec++; if ({bus.instr_code_high, bus.instr_code_low} !== 16'h5B00) begin n_err++; $display("FAIL redir_code: got %h want 5b00", {bus.instr_code_high, bus.instr_code_low}); end
        step();
        step();
        foreach (out_pc[i]) if (out_pc[i] == 16'h0010) seen_10 = 1'b1;
        n_vec++; if (seen_10) begin n_err++; $display("FAIL redir_discard: got 0010 in stream want absent"); end
        n_vec++; if (out_pc.size() < 3) begin n_err++; $display("FAIL redir_count: got %0d want >=3", out_pc.size()); end
        else begin
            n_vec++; if (out_pc[0] !== 16'h000E) begin n_err++; $display("FAIL redir_seq0: got %h want 000e", out_pc[0]); end
            n_vec++; if (out_pc[1] !== 16'h000F) begin n_err++; $display("FAIL redir_seq1: got %h want 000f", out_pc[1]); end
            n_vec++; if (out_pc[2] !== 16'h0100) begin n_err++; $display("FAIL redir_seq2: got %h want 0100", out_pc[2]); end
            n_vec++; if (out_code[0] !== 16'h5A0E) begin n_err++; $display("FAIL redir_code0: got %h want 5a0e", out_code[0]); end
        end
        xor_mask = '0;
    endtask

    task automatic test_wrap();
        boot_pc = 16'hFFFF; bus.instr_ready = 1'b1; bus.mem_gnt = 1'b1; enable = 1'b1;
        do_reset();
        repeat (5) step();
        n_vec++; if (out_pc.size() != 3) begin n_err++; $display("FAIL wrap_count: got %0d want 3", out_pc.size()); end
        else begin
            n_vec++; if (out_pc[0] !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pc0: got %h want ffff", out_pc[0]); end
            n_vec++; if (out_pc[1] !== 16'h0000) begin n_err++; $display("FAIL wrap_pc1: got %h want 0000", out_pc[1]); end
            n_vec++; if (out_pc[2] !== 16'h0001) begin n_err++; $display("FAIL wrap_pc2: got %h want 0001", out_pc[2]); end
            n_vec++; if (out_code[1] !== 16'h0000) begin n_err++; $display("FAIL wrap_code1: got %h want 0000", out_code[1]); end
        end
    endtask

    task automatic test_enable();
        int grants;
        grants = 0;
        boot_pc = 16'h0200; bus.instr_ready = 1'b0; bus.mem_gnt = 1'b1; enable = 1'b1;
        do_reset();
        step();
        enable = 1'b0;
        #1;
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL en_req: got %b want 0", bus.mem_req); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL en_occ0: got %0d want 0", occupancy); end
        step();
        n_vec++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL en_occ1: got %0d want 1", occupancy); end
        n_vec++; if (bus.instr_pc !== 16'h0200) begin n_err++; $display("FAIL en_pc: got %h want 0200", bus.instr_pc); end
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req) grants++;
            step();
        end
        n_vec++; if (grants != 0) begin n_err++; $display("FAIL en_grants: got %0d want 0", grants); end
        n_vec++; if (bus.mem_addr !== 16'h0201) begin n_err++; $display("FAIL en_addr: got %h want 0201", bus.mem_addr); end
        n_vec++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL en_occ_hold: got %0d want 1", occupancy); end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        #1;
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL en_drain: got %0d want 0", occupancy); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL en_valid: got %b want 0", bus.instr_valid); end
        enable = 1'b1;
    endtask

    task automatic test_reset_full();
        boot_pc = 16'h0300; bus.instr_ready = 1'b0; bus.mem_gnt = 1'b1; enable = 1'b1;
        do_reset();
        repeat (8) step();
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL rf_occ_full: got %0d want 4", occupancy); end
        boot_pc = 16'h0333;
        reset = 1'b1;
        step();
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rf_occ: got %0d want 0", occupancy); end
        n_vec++; if (bus.instr_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid: got %b want 0", bus.instr_valid); end
        n_vec++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rf_req: got %b want 0", bus.mem_req); end
        n_vec++; if (bus.mem_addr !== 16'h0333) begin n_err++; $display("FAIL rf_addr: got %h want 0333", bus.mem_addr); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot();
        test_back_to_back();
        test_full();
        test_grant_stall();
        test_redirect();
        test_wrap();
        test_enable();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
